// File: rtl/arith_pkg.sv
// Shared arithmetic types and constants for the lab datapath units.
package arith_pkg;

    localparam int unsigned DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; a 1-bit divider still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider4_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface seq_divider4_if
    import arith_pkg::*;
#(
    parameter int unsigned W = DIV_W
);
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         dz;

    modport master (output start, A, B, input Q, R, busy, done, dz);
    modport slave  (input start, A, B, output Q, R, busy, done, dz);
endinterface

// File: rtl/seq_divider4_sub_ripple.sv
// N-bit ripple-borrow subtractor: diff = x - y, bout set when x < y.
module sub_ripple #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         bout
);
    logic [N:0] b;

    assign b[0] = 1'b0;

    // Full-subtractor per bit; borrow ripples upward like the adder's carry.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign diff[i] = x[i] ^ y[i] ^ b[i];
        assign b[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b[i]);
    end

    assign bout = b[N];
endmodule

// File: rtl/seq_divider4.sv
// Restoring divider: one quotient bit per clock behind a start/done handshake.
module seq_divider4
    import arith_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider4_if.slave  bus
);
    localparam int unsigned CW = cnt_width(W);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  d, d_n;
    logic [W:0]    p, p_n;
    logic [W-1:0]  dvs, dvs_n;
    logic [W-1:0]  q, q_n;
    logic [W-1:0]  r, r_n;
    logic          dz, dz_n;
    logic          done, done_n;
    logic          busy, busy_n;

    logic [W:0]    t;
    logic [W:0]    diff;
    logic          bout;
    logic          unused_p_msb;

    // Partial remainder stays below the divisor, so its top bit never feeds back.
    assign unused_p_msb = p[W];

    assign t = {p[W-1:0], d[W-1]};

    sub_ripple #(.N(W + 1)) u_sub (
        .x    (t),
        .y    ({1'b0, dvs}),
        .diff (diff),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            d     <= '0;
            p     <= '0;
            dvs   <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            d     <= d_n;
            p     <= p_n;
            dvs   <= dvs_n;
            q     <= q_n;
            r     <= r_n;
            dz    <= dz_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

    // busy drops the cycle after the done pulse, which also blocks a start in that cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d;
        p_n     = p;
        dvs_n   = dvs;
        q_n     = q;
        r_n     = r;
        dz_n    = dz;
        done_n  = 1'b0;
        busy_n  = done ? 1'b0 : busy;
        case (state)
            IDLE: begin
                if (bus.start && !busy) begin
                    d_n     = bus.A;
                    dvs_n   = bus.B;
                    p_n     = '0;
                    cnt_n   = '0;
                    dz_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = (bus.B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                p_n   = bout ? t : diff;
                d_n   = (d << 1) | W'(!bout);
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
                if (dvs == '0) begin
                    q_n  = '1;
                    r_n  = d;
                    dz_n = 1'b1;
                end else begin
                    q_n  = d;
                    r_n  = p[W-1:0];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.Q    = q;
    assign bus.R    = r;
    assign bus.dz   = dz;
    assign bus.done = done;
    assign bus.busy = busy;
endmodule

// File: tb/tb_seq_divider4.sv
// Directed and exhaustive bench for the 4-bit sequential divider.
module tb_seq_divider4;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_divider4_if #(.W(4)) bus ();

    seq_divider4 #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One divide from an idle unit; optional ignored start pulse after edge pulse_at.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input int pulse_at,
                           output logic [3:0] q, output logic [3:0] r, output logic dz,
                           output int lat, output bit busy_ok);
        logic [3:0] q_prev;
        q_prev  = bus.Q;
        busy_ok = 1'b1;
        lat     = 0;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (i - 1 == pulse_at) begin
                bus.A     = 4'd6;
                bus.B     = 4'd3;
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (pulse_at >= 0) check("hold_q", 32'(bus.Q), 32'(q_prev));
        end
        if (!bus.busy) busy_ok = 1'b0;
        q  = bus.Q;
        r  = bus.R;
        dz = bus.dz;
        @(posedge clk);
        #1;
        if (bus.busy || bus.done) busy_ok = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input int pulse_at, input logic [3:0] eq, input logic [3:0] er,
                            input logic edz, input int elat);
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
        bit         busy_ok;
        run_div(a, b, pulse_at, q, r, dz, lat, busy_ok);
        check({tag, "_q"}, 32'(q), 32'(eq));
        check({tag, "_r"}, 32'(r), 32'(er));
        check({tag, "_dz"}, 32'(dz), 32'(edz));
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
        bit         busy_ok;
        bit         seen;
        logic [31:0] got;
        logic [31:0] exp;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 4'd0;
        bus.B     = 4'd0;
        #12;
        check("rst_out", 32'({bus.Q, bus.R, bus.busy, bus.done, bus.dz}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_out", 32'({bus.Q, bus.R, bus.busy, bus.done, bus.dz}), 32'd0);

        directed("d13_3", 4'd13, 4'd3, -1, 4'd4, 4'd1, 1'b0, 5);
        directed("d15_1", 4'd15, 4'd1, -1, 4'd15, 4'd0, 1'b0, 5);
        directed("d2_9", 4'd2, 4'd9, -1, 4'd0, 4'd2, 1'b0, 5);
        directed("d0_5", 4'd0, 4'd5, -1, 4'd0, 4'd0, 1'b0, 5);
        directed("d7_0", 4'd7, 4'd0, -1, 4'd15, 4'd7, 1'b1, 1);
        directed("d9_2", 4'd9, 4'd2, -1, 4'd4, 4'd1, 1'b0, 5);
        directed("d14_3p", 4'd14, 4'd3, 2, 4'd4, 4'd2, 1'b0, 5);

        // Reset in the middle of a divide.
        bus.A     = 4'd13;
        bus.B     = 4'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid", 32'({bus.Q, bus.R, bus.busy, bus.done, bus.dz}), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        directed("d10_4", 4'd10, 4'd4, -1, 4'd2, 4'd2, 1'b0, 5);

        // All operand pairs, back-to-back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(4'(a), 4'(b), -1, q, r, dz, lat, busy_ok);
                got = {19'd0, busy_ok, 3'(lat), dz, q, r};
                if (b == 0) exp = {19'd0, 1'b1, 3'd1, 1'b1, 4'hF, 4'(a)};
                else        exp = {19'd0, 1'b1, 3'd5, 1'b0, 4'(a / b), 4'(a % b)};
                check($sformatf("exh_%0d_%0d", a, b), got, exp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
